tile_buf_pingpong: RTL and testbench
====================================

Name: tile_buf_pingpong

Overview:
Parametrised double-buffered complex tile store. It replaces the fixed 4x4 kernel and image block memories.
- A loader writes a TILE x TILE complex tile as TILE/WR_ROWS narrow beats into the fill bank.
- The 2D FFT / multiply stage reads whole tiles in one request from the other, committed bank.
- Banks swap through commit/release handshakes, so loading overlaps computation.

Parameters:
DW, 11, bits per real/imag component (complex element = 2*DW, real in MSBs)
TILE, 4, tile edge; a tile holds TILE*TILE complex elements
WR_ROWS, 2, tile rows per write beat; TILE % WR_ROWS == 0 (elaboration error otherwise)
DEPTH_BITS, 9, tile address width per bank (2**DEPTH_BITS tiles per bank)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
wr_valid  in  1  write beat present
wr_ready  out  1  fill bank accepts beats (fill bank state != READY)
wr_addr  in  DEPTH_BITS  tile address, sampled on every accepted beat
wr_data  in  WR_ROWS*TILE*2*DW  WR_ROWS rows; element (row k, col c) at index k*TILE+c, index 0 in MSBs
wr_commit  in  1  fill bank complete; mark READY and toggle wr_sel
rd_req  in  1  tile read request
rd_addr  in  DEPTH_BITS  tile address
rd_valid  out  1  rd_data valid (one-cycle pulse per request)
rd_data  out  TILE*TILE*2*DW  full tile; element (r,c) at index r*TILE+c, index 0 in MSBs
rd_release  in  1  reader finished with read bank; mark FREE and toggle rd_sel
rd_bank_ready  out  1  read bank state == READY
err  out  3  sticky: [0] beat while !wr_ready, [1] commit with partial tile, [2] rd_req/rd_release on non-READY bank

Behaviour:
- Reset (synchronous, wins over all inputs)
  - Both banks FREE; wr_sel=0, rd_sel=0, beat=0.
  - wr_ready=1, rd_valid=0, rd_data=0, rd_bank_ready=0, err=0.
  - Memory contents are not cleared.
- Bank state per bank: FREE -> FILL on the first accepted beat; FILL or FREE -> READY on wr_commit (empty commit is legal); READY -> FREE on rd_release.
- Write beat
  - Accepted when wr_valid && wr_ready.
  - Writes rows beat*WR_ROWS .. beat*WR_ROWS+WR_ROWS-1 of tile wr_addr in bank wr_sel.
  - beat increments and wraps at TILE/WR_ROWS. Each beat may carry a different wr_addr; the row position comes only from beat.
  - wr_valid while !wr_ready: beat dropped, err[0] set.
- wr_commit
  - Ignored when the fill bank is READY (no state change).
  - When beat != 0: commit still applies, err[1] set, beat forced to 0.
  - A beat and a commit in the same cycle: the beat is written first, then the commit applies (beat counts toward completeness).
- Read
  - rd_req accepted only when rd_bank_ready. Array sampled at the t+1 edge; rd_valid=1 and rd_data at cycle t+2.
  - Back-to-back requests give one result per cycle.
  - rd_data holds its last value when rd_valid=0.
  - rd_req with !rd_bank_ready: no read, err[2] set.
- rd_release
  - On a READY bank: FREE at the next edge, rd_sel toggles.
  - On a non-READY bank: ignored, err[2] set.
  - A read accepted in the release cycle completes with that bank's old data. A write to the freed bank reaches the array no earlier than the t+2 edge, after the read sample at t+1.
- Commit on one bank and release on the other in the same cycle: both apply.
- Both banks READY: wr_ready=0 until a release.
- Reset during an in-flight read: the rd_valid pipeline is flushed; no pulse follows.
- Widths are pass-through only; no arithmetic on data.

Decomposition:
- Shared package (common definitions header):
  - Default constants CPLX_DW=11, TILE_DEF=4.
  - Bank-state enum {FREE, FILL, READY}.
  - Error-bit index constants.
  - Pack/unpack functions between flat vectors and element index.
- Sub-module tile_buf_bank:
  - One bank built as TILE/WR_ROWS sub-memories, each WR_ROWS*TILE*2*DW wide and 2**DEPTH_BITS deep.
  - Per-sub-memory write enable; common registered read address.
  - Instantiated twice.
- The top level owns the bank FSMs, beat counter, rd_valid pipeline and error logic.

Test Plan:
- Reset then idle: wr_ready=1, rd_bank_ready=0, rd_valid=0, err=0 for 10 cycles.
- Fill tile 5 of bank 0 with 2 beats (element value = r*4+c real, negated imag), commit, rd_req addr 5 -> rd_valid at t+2, all 16 elements match, rd_data=0 on other cycles.
- Ping-pong: commit bank 0, fill bank 1 during 8 back-to-back reads of bank 0 -> 8 consecutive rd_valid pulses with correct data. Release, then reads return bank 1 data.
- Both banks READY: wr_valid held -> wr_ready=0, beat dropped, err=3'b001, bank data unchanged on readback.
- Commit after 1 beat -> err[1]=1, bank READY, next fill begins at beat 0 (rows 0-1).
- rd_req and rd_release in the same cycle, with a write to the freed bank at t+1 -> rd_data equals the old contents. Reset asserted at t+1 of another read -> no rd_valid pulse.

Source files
------------

// File: rtl/tile_buf_pingpong_pkg.sv
// Shared definitions for the ping-pong tile buffer: defaults, bank states,
// error-bit positions and flat-vector element helpers.
package tile_buf_pingpong_pkg;

  localparam int CPLX_DW  = 11;
  localparam int TILE_DEF = 4;

  typedef enum logic [1:0] {
    BANK_FREE  = 2'd0,
    BANK_FILL  = 2'd1,
    BANK_READY = 2'd2
  } bank_state_e;

  localparam int ERR_BEAT_DROP = 0;
  localparam int ERR_PARTIAL   = 1;
  localparam int ERR_RD_STATE  = 2;

  // Flat vectors keep element 0 in the MSBs.
  function automatic int elem_lsb(input int idx, input int n_elems, input int elem_w);
    return (n_elems - 1 - idx) * elem_w;
  endfunction

  function automatic int elem_index(input int row, input int col, input int tile);
    return row * tile + col;
  endfunction

endpackage

// File: rtl/tile_buf_bank.sv
// One tile bank: TILE/WR_ROWS row-group memories written per beat and read
// together through a shared registered read address.
module tile_buf_bank
  import tile_buf_pingpong_pkg::*;
#(
  parameter int  DW         = CPLX_DW,
  parameter int  TILE       = TILE_DEF,
  parameter int  WR_ROWS    = 2,
  parameter int  DEPTH_BITS = 9,
  localparam int NSUB       = TILE / WR_ROWS,
  localparam int BEAT_W     = (NSUB > 1) ? $clog2(NSUB) : 1,
  localparam int SUB_W      = WR_ROWS * TILE * 2 * DW,
  localparam int TILE_W     = TILE * TILE * 2 * DW
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [BEAT_W-1:0]     wr_beat_i,
  input  logic [DEPTH_BITS-1:0] wr_addr_i,
  input  logic [SUB_W-1:0]      wr_data_i,
  input  logic                  rd_en_i,
  input  logic [DEPTH_BITS-1:0] rd_addr_i,
  output logic [TILE_W-1:0]     rd_data_o
);

  logic [DEPTH_BITS-1:0] rd_addr_q;

  always_ff @(posedge clk) begin
    if (rd_en_i) rd_addr_q <= rd_addr_i;
  end

  for (genvar s = 0; s < NSUB; s++) begin : g_sub
    localparam int LSB = elem_lsb(s, NSUB, SUB_W);
    logic [SUB_W-1:0] mem_q [2**DEPTH_BITS];

    always_ff @(posedge clk) begin
      if (wr_en_i && (wr_beat_i == BEAT_W'(s))) mem_q[wr_addr_i] <= wr_data_i;
    end

    assign rd_data_o[LSB +: SUB_W] = mem_q[rd_addr_q];
  end

endmodule

// File: rtl/tile_buf_pingpong.sv
// Double-buffered complex tile store: a loader fills one bank in narrow beats
// while the compute stage reads whole tiles from the committed bank.
module tile_buf_pingpong
  import tile_buf_pingpong_pkg::*;
#(
  parameter int  DW         = CPLX_DW,
  parameter int  TILE       = TILE_DEF,
  parameter int  WR_ROWS    = 2,
  parameter int  DEPTH_BITS = 9,
  localparam int NSUB       = TILE / WR_ROWS,
  localparam int BEAT_W     = (NSUB > 1) ? $clog2(NSUB) : 1,
  localparam int SUB_W      = WR_ROWS * TILE * 2 * DW,
  localparam int TILE_W     = TILE * TILE * 2 * DW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DEPTH_BITS-1:0] wr_addr,
  input  logic [SUB_W-1:0]      wr_data,
  input  logic                  wr_commit,
  input  logic                  rd_req,
  input  logic [DEPTH_BITS-1:0] rd_addr,
  output logic                  rd_valid,
  output logic [TILE_W-1:0]     rd_data,
  input  logic                  rd_release,
  output logic                  rd_bank_ready,
  output logic [2:0]            err
);

  if (TILE % WR_ROWS != 0) begin : g_bad_cfg
    $error("tile_buf_pingpong: TILE must be a multiple of WR_ROWS");
  end

  bank_state_e       state_q [2];
  bank_state_e       state_d [2];
  logic              wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic [BEAT_W-1:0] beat_q, beat_d, beat_inc;
  logic [2:0]        err_q, err_d;
  logic              beat_acc, commit_acc, rd_acc, rel_acc;
  logic              rd_p1_q, rd_bank_q, rd_valid_q;
  logic [TILE_W-1:0] rd_data_q;
  logic [TILE_W-1:0] bank_rd_data [2];

  // Handshakes: a beat transfers when wr_valid && wr_ready in the same cycle;
  // rd_req/rd_release act only while rd_bank_ready, and each accepted rd_req
  // yields exactly one rd_valid pulse two cycles later with no back-pressure.
  always_comb begin
    wr_ready      = (state_q[wr_sel_q] != BANK_READY);
    rd_bank_ready = (state_q[rd_sel_q] == BANK_READY);
    beat_acc      = wr_valid && wr_ready;
    commit_acc    = wr_commit && wr_ready;
    rd_acc        = rd_req && rd_bank_ready;
    rel_acc       = rd_release && rd_bank_ready;
    beat_inc      = (beat_q == BEAT_W'(NSUB - 1)) ? '0 : beat_q + BEAT_W'(1);

    state_d  = state_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    err_d    = err_q;
    beat_d   = beat_acc ? beat_inc : beat_q;

    if (wr_valid && !wr_ready) err_d[ERR_BEAT_DROP] = 1'b1;
    if ((rd_req || rd_release) && !rd_bank_ready) err_d[ERR_RD_STATE] = 1'b1;

    if (beat_acc && (state_q[wr_sel_q] == BANK_FREE)) state_d[wr_sel_q] = BANK_FILL;

    // The same-cycle beat has already advanced beat_d, so it counts toward completeness.
    if (commit_acc) begin
      if (beat_d != '0) err_d[ERR_PARTIAL] = 1'b1;
      beat_d             = '0;
      state_d[wr_sel_q]  = BANK_READY;
      wr_sel_d           = ~wr_sel_q;
    end

    if (rel_acc) begin
      state_d[rd_sel_q] = BANK_FREE;
      rd_sel_d          = ~rd_sel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q[0] <= BANK_FREE;
      state_q[1] <= BANK_FREE;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      beat_q     <= '0;
      err_q      <= '0;
      rd_p1_q    <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
      rd_p1_q    <= rd_acc;
      if (rd_acc) rd_bank_q <= rd_sel_q;
      rd_valid_q <= rd_p1_q;
      if (rd_p1_q) rd_data_q <= bank_rd_data[rd_bank_q];
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    tile_buf_bank #(
      .DW        (DW),
      .TILE      (TILE),
      .WR_ROWS   (WR_ROWS),
      .DEPTH_BITS(DEPTH_BITS)
    ) u_bank (
      .clk      (clk),
      .wr_en_i  (beat_acc && (wr_sel_q == 1'(b))),
      .wr_beat_i(beat_q),
      .wr_addr_i(wr_addr),
      .wr_data_i(wr_data),
      .rd_en_i  (rd_acc),
      .rd_addr_i(rd_addr),
      .rd_data_o(bank_rd_data[b])
    );
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign err      = err_q;

endmodule

// File: tb/tb_tile_buf_pingpong.sv
// Bench for tile_buf_pingpong: control-path vector table, directed multi-cycle
// sequences and a randomized run, all checked against a tile-level model.
module tb_tile_buf_pingpong;

  localparam int DW = 11, TILE = 4, WR_ROWS = 2, DB = 9;
  localparam int EW = 2 * DW, NE = TILE * TILE, WE = WR_ROWS * TILE;
  localparam int SUB_W = WE * EW, TILE_W = NE * EW, NA = 16;

  logic              clk = 1'b0;
  logic              reset, wr_valid, wr_ready, wr_commit;
  logic              rd_req, rd_valid, rd_release, rd_bank_ready;
  logic [DB-1:0]     wr_addr, rd_addr;
  logic [SUB_W-1:0]  wr_data;
  logic [TILE_W-1:0] rd_data;
  logic [2:0]        err;

  tile_buf_pingpong #(.DW(DW), .TILE(TILE), .WR_ROWS(WR_ROWS), .DEPTH_BITS(DB)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_commit(wr_commit),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_release(rd_release), .rd_bank_ready(rd_bank_ready), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, cyc = 0, pulses = 0;

  // Reference model: which banks hold a committed tile, where the loader and
  // reader point, how many rows of the current tile are loaded, tile contents.
  logic              m_ready [2];
  logic              m_wsel, m_rsel;
  int                m_rows;
  logic [2:0]        m_err;
  logic [EW-1:0]     m_mem [2][NA][NE];
  logic [TILE-1:0]   m_known [2][NA];
  logic [TILE_W-1:0] exp_q[$];
  int                due_q[$];
  logic [TILE_W-1:0] m_last;

  typedef struct {
    logic       wv, wc, rq, rl;
    logic       exp_wr_ready, exp_rbr;
    logic [2:0] exp_err;
  } vec_t;
  vec_t vecs[14];

  task automatic chk(input string name, input logic [TILE_W-1:0] act, input logic [TILE_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle();
    reset = 1'b0; wr_valid = 1'b0; wr_commit = 1'b0; rd_req = 1'b0; rd_release = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
  endtask

  function automatic logic [EW-1:0] pat_elem(input int v);
    logic [DW-1:0] re, im;
    re = DW'(v);
    im = DW'(-v);
    return {re, im};
  endfunction

  function automatic logic [SUB_W-1:0] pat_beat(input int beat, input int base);
    logic [SUB_W-1:0] d = '0;
    for (int k = 0; k < WR_ROWS; k++)
      for (int c = 0; c < TILE; c++)
        d[(WE - 1 - (k * TILE + c)) * EW +: EW] = pat_elem(base + (beat * WR_ROWS + k) * TILE + c);
    return d;
  endfunction

  function automatic logic [TILE_W-1:0] pat_tile(input int base);
    logic [TILE_W-1:0] t = '0;
    for (int e = 0; e < NE; e++) t[(NE - 1 - e) * EW +: EW] = pat_elem(base + e);
    return t;
  endfunction

  function automatic logic [SUB_W-1:0] rand_beat();
    logic [SUB_W-1:0] d = '0;
    for (int i = 0; i < WE; i++) d[i * EW +: EW] = EW'($urandom);
    return d;
  endfunction

  function automatic logic [TILE_W-1:0] tile_of(input logic b, input int a);
    logic [TILE_W-1:0] t = '0;
    for (int e = 0; e < NE; e++) t[(NE - 1 - e) * EW +: EW] = m_mem[b][a][e];
    return t;
  endfunction

  // Apply the current inputs to the model as the next clock edge would.
  task automatic model_step();
    logic fill_open, rd_open;
    int   wa, row;
    if (reset) begin
      m_ready[0] = 1'b0; m_ready[1] = 1'b0; m_wsel = 1'b0; m_rsel = 1'b0;
      m_rows = 0; m_err = '0; m_last = '0;
      exp_q.delete(); due_q.delete();
      return;
    end
    fill_open = !m_ready[m_wsel];
    rd_open   = m_ready[m_rsel];
    if (rd_req && rd_open) begin
      exp_q.push_back(tile_of(m_rsel, int'(rd_addr)));
      due_q.push_back(cyc + 2);
    end
    if ((rd_req || rd_release) && !rd_open) m_err[2] = 1'b1;
    if (wr_valid && !fill_open) m_err[0] = 1'b1;
    if (wr_valid && fill_open) begin
      wa = int'(wr_addr);
      for (int k = 0; k < WR_ROWS; k++) begin
        row = m_rows + k;
        m_known[m_wsel][wa][row] = 1'b1;
        for (int c = 0; c < TILE; c++)
          m_mem[m_wsel][wa][row * TILE + c] = wr_data[(WE - 1 - (k * TILE + c)) * EW +: EW];
      end
      m_rows = (m_rows + WR_ROWS) % TILE;
    end
    if (wr_commit && fill_open) begin
      if (m_rows != 0) m_err[1] = 1'b1;
      m_rows = 0;
      m_ready[m_wsel] = 1'b1;
      m_wsel = ~m_wsel;
    end
    if (rd_release && rd_open) begin
      m_ready[m_rsel] = 1'b0;
      m_rsel = ~m_rsel;
    end
  endtask

  // One clock: model the edge, cross it, check every output at the falling edge.
  task automatic tick();
    model_step();
    @(negedge clk);
    cyc++;
    chk("wr_ready", wr_ready, !m_ready[m_wsel]);
    chk("rd_bank_ready", rd_bank_ready, m_ready[m_rsel]);
    chk("err", err, m_err);
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      chk("rd_valid", rd_valid, 1'b1);
      chk("rd_data", rd_data, exp_q[0]);
      m_last = exp_q.pop_front();
      void'(due_q.pop_front());
    end else begin
      chk("rd_valid_idle", rd_valid, 1'b0);
      chk("rd_data_hold", rd_data, m_last);
    end
    if (rd_valid) pulses++;
    idle();
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < NA; a++) m_known[b][a] = '0;
    m_last = '0;
    idle();

    //          wv wc rq rl  wr_ready rbr  err
    vecs[0]  = '{0, 0, 0, 0, 1, 0, 3'b000};
    vecs[1]  = '{0, 0, 1, 0, 1, 0, 3'b100};
    vecs[2]  = '{1, 0, 0, 0, 1, 0, 3'b100};
    vecs[3]  = '{1, 1, 0, 0, 1, 1, 3'b100};
    vecs[4]  = '{0, 1, 0, 0, 0, 1, 3'b100};
    vecs[5]  = '{1, 0, 0, 0, 0, 1, 3'b101};
    vecs[6]  = '{0, 1, 0, 0, 0, 1, 3'b101};
    vecs[7]  = '{0, 0, 0, 1, 1, 1, 3'b101};
    vecs[8]  = '{1, 0, 0, 0, 1, 1, 3'b101};
    vecs[9]  = '{0, 1, 0, 0, 0, 1, 3'b111};
    vecs[10] = '{0, 0, 0, 1, 1, 1, 3'b111};
    vecs[11] = '{0, 1, 0, 1, 1, 1, 3'b111};
    vecs[12] = '{0, 0, 0, 1, 1, 0, 3'b111};
    vecs[13] = '{1, 1, 0, 0, 1, 1, 3'b111};

    @(negedge clk);
    reset = 1'b1;
    tick();
    for (int i = 0; i < 14; i++) begin
      wr_valid = vecs[i].wv; wr_commit = vecs[i].wc;
      rd_req = vecs[i].rq; rd_release = vecs[i].rl;
      wr_addr = DB'(15); rd_addr = DB'(15); wr_data = rand_beat();
      tick();
      chk($sformatf("vec%0d wr_ready", i), wr_ready, vecs[i].exp_wr_ready);
      chk($sformatf("vec%0d rd_bank_ready", i), rd_bank_ready, vecs[i].exp_rbr);
      chk($sformatf("vec%0d err", i), err, vecs[i].exp_err);
    end

    // Reset then idle.
    reset = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle wr_ready", wr_ready, 1'b1);
      chk("idle rd_bank_ready", rd_bank_ready, 1'b0);
      chk("idle rd_valid", rd_valid, 1'b0);
      chk("idle err", err, 3'b000);
      chk("idle rd_data", rd_data, '0);
    end

    // Tile 5 of bank 0 with the r*4+c pattern, then a single read.
    for (int b = 0; b < 2; b++) begin
      wr_valid = 1'b1; wr_addr = DB'(5); wr_data = pat_beat(b, 0);
      tick();
    end
    wr_commit = 1'b1;
    tick();
    rd_req = 1'b1; rd_addr = DB'(5);
    tick();
    chk("first rd t+1 valid", rd_valid, 1'b0);
    chk("first rd t+1 data", rd_data, '0);
    tick();
    chk("first rd t+2 valid", rd_valid, 1'b1);
    for (int e = 0; e < NE; e++)
      chk($sformatf("tile5 elem%0d", e), rd_data[(NE - 1 - e) * EW +: EW], pat_elem(e));
    tick();
    chk("first rd after valid", rd_valid, 1'b0);

    // Fill bank 1 while reading bank 0 back to back.
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      rd_req = 1'b1; rd_addr = DB'(5);
      wr_valid = 1'b1; wr_addr = DB'(i / 2); wr_data = rand_beat();
      tick();
    end
    wr_commit = 1'b1;
    tick();
    tick();
    chk("pingpong pulses", pulses, 8);
    rd_release = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      rd_req = 1'b1; rd_addr = DB'(i);
      tick();
    end
    tick(); tick();

    // Both banks READY: beats are dropped and bank 1 data is untouched.
    wr_valid = 1'b1; wr_addr = DB'(6); wr_data = pat_beat(0, 32);
    tick();
    wr_valid = 1'b1; wr_addr = DB'(6); wr_data = pat_beat(1, 32); wr_commit = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_addr = DB'(0); wr_data = rand_beat();
      tick();
      chk("both ready wr_ready", wr_ready, 1'b0);
    end
    chk("both ready err", err, 3'b001);
    rd_req = 1'b1; rd_addr = DB'(0);
    tick(); tick(); tick();

    // Partial commit, then the next fill starts at rows 0-1.
    rd_release = 1'b1;
    tick();
    wr_valid = 1'b1; wr_addr = DB'(1); wr_data = rand_beat();
    tick();
    wr_commit = 1'b1;
    tick();
    chk("partial commit err", err, 3'b011);
    chk("partial commit bank ready", rd_bank_ready, 1'b1);
    rd_release = 1'b1;
    tick();
    for (int b = 0; b < 2; b++) begin
      wr_valid = 1'b1; wr_addr = DB'(7); wr_data = pat_beat(b, 64);
      tick();
    end
    wr_commit = 1'b1;
    tick();
    rd_release = 1'b1;
    tick();
    rd_req = 1'b1; rd_addr = DB'(7);
    tick(); tick();
    chk("refill rows from 0", rd_data, pat_tile(64));

    // Read and release together; the freed bank is rewritten one cycle later.
    wr_commit = 1'b1;
    tick();
    rd_req = 1'b1; rd_release = 1'b1; rd_addr = DB'(7);
    tick();
    chk("freed bank wr_ready", wr_ready, 1'b1);
    wr_valid = 1'b1; wr_addr = DB'(7); wr_data = pat_beat(0, 96);
    tick();
    chk("release read valid", rd_valid, 1'b1);
    chk("release read old data", rd_data, pat_tile(64));

    // Reset while a read is in flight.
    rd_req = 1'b1; rd_addr = DB'(0);
    tick();
    pulses = 0;
    reset = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    chk("reset flush pulses", pulses, 0);

    // Randomized traffic.
    reset = 1'b1;
    tick();
    for (int i = 0; i < 800; i++) begin
      int a;
      reset      = ($urandom_range(0, 199) == 0);
      wr_valid   = 1'($urandom_range(0, 1));
      wr_addr    = DB'($urandom_range(0, 7));
      wr_data    = rand_beat();
      wr_commit  = ($urandom_range(0, 7) == 0);
      rd_release = ($urandom_range(0, 11) == 0);
      a          = $urandom_range(0, 7);
      rd_addr    = DB'(a);
      if (m_ready[m_rsel]) rd_req = (m_known[m_rsel][a] == '1) && ($urandom_range(0, 1) == 1);
      else rd_req = ($urandom_range(0, 9) == 0);
      tick();
    end
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
